// File: rtl/condlogic_it_if.sv
// ============================================================================
// condlogic_it_if : decoder/FSM <-> conditional-logic signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface condlogic_it_if #(
  parameter int FLAG_GROUPS = 2,
  parameter int IT_MAX      = 4
);
  localparam int CW = $clog2(IT_MAX + 1);

  logic [3:0]             Cond;
  logic [3:0]             ALUFlags;
  logic [FLAG_GROUPS-1:0] FlagW;
  logic                   PCS;
  logic                   NextPC;
  logic                   RegW;
  logic                   MemW;
  logic                   CondLatch;
  logic                   InstrDone;
  logic                   ITStart;
  logic [3:0]             ITCond;
  logic [CW-1:0]          ITCount;
  logic [IT_MAX-1:0]      ITElse;
  logic                   PCWrite;
  logic                   RegWrite;
  logic                   MemWrite;
  logic [3:0]             Flags;
  logic                   CondExQ;
  logic                   ITActive;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
           CondLatch, InstrDone, ITStart, ITCond, ITCount, ITElse,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExQ, ITActive
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
           CondLatch, InstrDone, ITStart, ITCond, ITCount, ITElse,
    output PCWrite, RegWrite, MemWrite, Flags, CondExQ, ITActive
  );
endinterface

`default_nettype wire

// File: rtl/condlogic_it.sv
// ============================================================================
// condlogic_it : latched ARM condition evaluation, grouped flag writes, IT blocks
// Revision 1.0
// ============================================================================
`default_nettype none

module condlogic_it #(
  parameter int FLAG_GROUPS = 2,
  parameter int IT_MAX      = 4
) (
  input  logic          clk,
  input  logic          reset,
  condlogic_it_if.slave bus
);
  localparam int CW = $clog2(IT_MAX + 1);
  localparam int GW = 4 / FLAG_GROUPS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0]        it_cond_q;
  logic [CW-1:0]     remain_q;
  logic [IT_MAX-1:0] mask_q;
  logic [3:0]        flags_q;
  logic [3:0]        flags_d;
  logic              condex_q;
  logic [3:0]        ec;
  logic              cond_ok;
  logic [CW-1:0]     it_count_clamped;

  function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: condcheck = z;
      4'b0001: condcheck = ~z;
      4'b0010: condcheck = cy;
      4'b0011: condcheck = ~cy;
      4'b0100: condcheck = n;
      4'b0101: condcheck = ~n;
      4'b0110: condcheck = v;
      4'b0111: condcheck = ~v;
      4'b1000: condcheck = cy & ~z;
      4'b1001: condcheck = ~cy | z;
      4'b1010: condcheck = (n == v);
      4'b1011: condcheck = (n != v);
      4'b1100: condcheck = ~z & (n == v);
      4'b1101: condcheck = z | (n != v);
      default: condcheck = 1'b1;
    endcase
  endfunction

  // AL and the unconditional code have no meaningful inverse inside an IT block
  always_comb begin
    ec = bus.Cond;
    if (state_q == S_ACTIVE) begin
      if (it_cond_q[3:1] == 3'b111) ec = it_cond_q;
      else                          ec = it_cond_q ^ {3'b000, mask_q[0]};
    end
  end

  assign cond_ok = condcheck(ec, flags_q);

  assign it_count_clamped = (bus.ITCount > CW'(IT_MAX)) ? CW'(IT_MAX) : bus.ITCount;

  // Gated by the latched result so mid-instruction flag updates cannot self-predicate
  always_comb begin
    flags_d = flags_q;
    for (int g = 0; g < FLAG_GROUPS; g++) begin
      if (bus.FlagW[g] && condex_q) flags_d[g*GW +: GW] = bus.ALUFlags[g*GW +: GW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      it_cond_q <= 4'b0000;
      remain_q  <= '0;
      mask_q    <= '0;
      flags_q   <= 4'b0000;
      condex_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (bus.CondLatch) condex_q <= (state_q == S_IDLE && bus.ITStart) ? 1'b1 : cond_ok;
      case (state_q)
        S_IDLE: begin
          if (bus.CondLatch && bus.ITStart && (bus.ITCount != '0)) begin
            state_q   <= S_ARMED;
            it_cond_q <= bus.ITCond;
            remain_q  <= it_count_clamped;
            mask_q    <= bus.ITElse;
          end
        end
        S_ARMED: begin
          if (bus.InstrDone) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (bus.InstrDone) begin
            remain_q <= remain_q - CW'(1);
            mask_q   <= mask_q >> 1;
            if (remain_q <= CW'(1)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RegWrite = bus.RegW & condex_q;
  assign bus.MemWrite = bus.MemW & condex_q;
  assign bus.PCWrite  = (bus.PCS & condex_q) | bus.NextPC;
  assign bus.Flags    = flags_q;
  assign bus.CondExQ  = condex_q;
  assign bus.ITActive = (state_q == S_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_condlogic_it.sv
// ============================================================================
// tb_condlogic_it : directed self-checking bench for condlogic_it
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_condlogic_it;
  localparam int FLAG_GROUPS = 2;
  localparam int IT_MAX      = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  condlogic_it_if #(.FLAG_GROUPS(FLAG_GROUPS), .IT_MAX(IT_MAX)) bus ();

  condlogic_it #(.FLAG_GROUPS(FLAG_GROUPS), .IT_MAX(IT_MAX)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write all flags through an AL-latched instruction
  task automatic set_flags(input logic [3:0] f);
    bus.Cond = 4'b1110; bus.CondLatch = 1'b1;
    tick();
    bus.CondLatch = 1'b0; bus.ALUFlags = f; bus.FlagW = '1;
    tick();
    bus.FlagW = '0; bus.ALUFlags = 4'b0000;
  endtask

  task automatic latch(input logic [3:0] c);
    bus.Cond = c; bus.CondLatch = 1'b1;
    tick();
    bus.CondLatch = 1'b0;
  endtask

  task automatic it_start(input logic [3:0] cnd, input logic [2:0] cnt, input logic [3:0] els);
    bus.ITStart = 1'b1; bus.ITCond = cnd; bus.ITCount = cnt; bus.ITElse = els;
    latch(4'b1110);
    bus.ITStart = 1'b0;
    check("it_self_exec", 16'(bus.CondExQ), 16'h1);
    bus.InstrDone = 1'b1;
    tick();
    bus.InstrDone = 1'b0;
  endtask

  task automatic instr(input string tag, input logic exp_cx, input logic exp_act_after);
    bus.RegW = 1'b1;
    latch(4'b1110);
    check({tag, "_cx"}, 16'(bus.CondExQ), 16'(exp_cx));
    check({tag, "_regw"}, 16'(bus.RegWrite), 16'(exp_cx));
    bus.InstrDone = 1'b1;
    tick();
    bus.InstrDone = 1'b0; bus.RegW = 1'b0;
    check({tag, "_act"}, 16'(bus.ITActive), 16'(exp_act_after));
  endtask

  logic [15:0] tbl_exp [3];
  logic [3:0]  tbl_flg [3];

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0;
    bus.Cond = 4'b0; bus.ALUFlags = 4'b0; bus.FlagW = '0; bus.PCS = 1'b0;
    bus.NextPC = 1'b1; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.CondLatch = 1'b0;
    bus.InstrDone = 1'b0; bus.ITStart = 1'b0; bus.ITCond = 4'b0; bus.ITCount = '0;
    bus.ITElse = '0;
    #1;
    check("rst_flags", 16'(bus.Flags), 16'h0);
    check("rst_cx", 16'(bus.CondExQ), 16'h0);
    check("rst_act", 16'(bus.ITActive), 16'h0);
    check("rst_pcw", 16'(bus.PCWrite), 16'h1);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: latch of AL enables writes the following cycle
    bus.NextPC = 1'b0; bus.RegW = 1'b1; bus.Cond = 4'b1110;
    #1 check("t1_regw_pre", 16'(bus.RegWrite), 16'h0);
    latch(4'b1110);
    check("t1_regw_post", 16'(bus.RegWrite), 16'h1);
    check("t1_flags", 16'(bus.Flags), 16'h0);
    bus.RegW = 1'b0;

    // 2: grouped flag writes
    bus.ALUFlags = 4'b1011; bus.FlagW = 2'b01;
    tick();
    check("t2_cv", 16'(bus.Flags), 16'h3);
    bus.ALUFlags = 4'b0100; bus.FlagW = 2'b10;
    tick();
    bus.FlagW = 2'b00;
    check("t2_nz", 16'(bus.Flags), 16'h7);
    latch(4'b0000);
    check("t2_eq", 16'(bus.CondExQ), 16'h1);
    latch(4'b1010);
    check("t2_ge", 16'(bus.CondExQ), 16'h0);

    // 3: failed condition suppresses all side effects for the whole instruction
    set_flags(4'b0000);
    latch(4'b0000);
    check("t3_cx", 16'(bus.CondExQ), 16'h0);
    bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1; bus.ALUFlags = 4'b0100; bus.FlagW = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_regw", 16'(bus.RegWrite), 16'h0);
      check("t3_memw", 16'(bus.MemWrite), 16'h0);
      check("t3_pcw", 16'(bus.PCWrite), 16'h0);
      tick();
    end
    bus.NextPC = 1'b1;
    #1 check("t3_pcw_next", 16'(bus.PCWrite), 16'h1);
    check("t3_flags", 16'(bus.Flags), 16'h0);
    bus.RegW = 1'b0; bus.MemW = 1'b0; bus.PCS = 1'b0; bus.FlagW = '0; bus.NextPC = 1'b0;

    // condition table: bit k = expected result of code k
    tbl_flg[0] = 4'b1000; tbl_exp[0] = 16'hEA9A;
    tbl_flg[1] = 4'b0110; tbl_exp[1] = 16'hE6A5;
    tbl_flg[2] = 4'b0010; tbl_exp[2] = 16'hD5A6;
    for (int t = 0; t < 3; t++) begin
      set_flags(tbl_flg[t]);
      for (int c = 0; c < 16; c++) begin
        latch(4'(c));
        check($sformatf("cond_f%h_c%0d", tbl_flg[t], c), 16'(bus.CondExQ), 16'(tbl_exp[t][c]));
      end
    end

    // 4: IT EQ, else pattern 010 with Z=1
    set_flags(4'b0100);
    it_start(4'b0000, 3'd3, 4'b0010);
    check("t4_active", 16'(bus.ITActive), 16'h1);
    instr("t4_i0", 1'b1, 1'b1);
    instr("t4_i1", 1'b0, 1'b1);
    instr("t4_i2", 1'b1, 1'b0);

    // 5: zero count stays idle; oversize count clamps
    it_start(4'b0000, 3'd0, 4'b0000);
    check("t5_zero_idle", 16'(bus.ITActive), 16'h0);
    it_start(4'b0000, 3'd7, 4'b0000);
    instr("t5_i0", 1'b1, 1'b1);
    instr("t5_i1", 1'b1, 1'b1);
    instr("t5_i2", 1'b1, 1'b1);
    instr("t5_i3", 1'b1, 1'b0);
    latch(4'b0001);
    check("t5_after_ne", 16'(bus.CondExQ), 16'h0);

    // 6: async reset mid-block
    it_start(4'b0000, 3'd3, 4'b0000);
    instr("t6_i0", 1'b1, 1'b1);
    instr("t6_i1", 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_act", 16'(bus.ITActive), 16'h0);
    check("t6_rst_cx", 16'(bus.CondExQ), 16'h0);
    check("t6_rst_flags", 16'(bus.Flags), 16'h0);
    #1 reset = 1'b1;
    tick();
    latch(4'b1110);
    check("t6_own_al", 16'(bus.CondExQ), 16'h1);
    latch(4'b0000);
    check("t6_own_eq", 16'(bus.CondExQ), 16'h0);
    check("t6_idle", 16'(bus.ITActive), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
